// File: rtl/sqrt2_seq_if.sv
// rtl/sqrt2_seq_if.sv - operand/result stream bundle between sqrt2_seq and its clients
interface sqrt2_seq_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_nan;
  logic        out_pinf;
  logic        out_ninf;
  logic        out_timeout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_nan, out_pinf, out_ninf, out_timeout, out_valid, busy
  );

  modport slave (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_nan, out_pinf, out_ninf, out_timeout, out_valid, busy
  );
endinterface

// File: rtl/sqrt2_seq.sv
// rtl/sqrt2_seq.sv - bus sequencer feeding one sqrt2 unit over its shared tri-state data bus
// Optional WAIT-state abort enabled by defining SQRT2_SEQ_TIMEOUT_EN.
module sqrt2_seq #(
  parameter int LOAD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  sqrt2_seq_if.master strm,
  inout  wire  [15:0] sq_io_data,
  output logic        sq_enable,
  input  logic        sq_result,
  input  logic        sq_is_nan,
  input  logic        sq_is_pinf,
  input  logic        sq_is_ninf
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  // A misconfigured instance never accepts work rather than sequencing with wrapped counters.
  localparam bit CFG_OK = (LOAD_CYCLES >= 1) && (GAP_CYCLES >= 1) && (TIMEOUT_CYCLES >= 1) &&
                          (LOAD_CYCLES <= (1 << CNT_W)) && (GAP_CYCLES <= (1 << CNT_W)) &&
                          (TIMEOUT_CYCLES <= (1 << CNT_W));

`ifdef SQRT2_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic out_timeout_q;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      op_reg;
  logic [15:0]      out_data_q;
  logic             out_nan_q;
  logic             out_pinf_q;
  logic             out_ninf_q;
  logic             out_valid_q;
  logic             bus_oe;
  logic             out_free;
  logic             accept;

  assign strm.in_ready = (state == ST_IDLE) && !reset && CFG_OK;
  assign accept        = strm.in_valid && strm.in_ready;
  assign out_free      = !out_valid_q || strm.out_ready;

  assign sq_enable  = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_HOLD);
  assign bus_oe     = (state == ST_LOAD);
  assign sq_io_data = bus_oe ? op_reg : 16'hzzzz;

  assign strm.out_data  = out_data_q;
  assign strm.out_nan   = out_nan_q;
  assign strm.out_pinf  = out_pinf_q;
  assign strm.out_ninf  = out_ninf_q;
  assign strm.out_valid = out_valid_q;
  assign strm.busy      = (state != ST_IDLE);
`ifdef SQRT2_SEQ_TIMEOUT_EN
  assign strm.out_timeout = out_timeout_q;
`else
  assign strm.out_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      op_reg      <= '0;
      out_data_q  <= '0;
      out_nan_q   <= 1'b0;
      out_pinf_q  <= 1'b0;
      out_ninf_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SQRT2_SEQ_TIMEOUT_EN
      out_timeout_q <= 1'b0;
`endif
    end else begin
      // Consume first; a capture later in this block overrides it so a same-edge reload stays valid.
      if (out_valid_q && strm.out_ready) out_valid_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_reg <= strm.in_data;
            cnt    <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt == LOAD_LAST) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          // With the output register blocked, ENABLE stays high and sqrt2 keeps its result.
          if (sq_result && out_free) begin
            out_data_q  <= sq_io_data;
            out_nan_q   <= sq_is_nan;
            out_pinf_q  <= sq_is_pinf;
            out_ninf_q  <= sq_is_ninf;
            out_valid_q <= 1'b1;
`ifdef SQRT2_SEQ_TIMEOUT_EN
            out_timeout_q <= 1'b0;
`endif
            cnt   <= '0;
            state <= ST_HOLD;
          end
`ifdef SQRT2_SEQ_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            if (out_free) begin
              out_data_q    <= 16'hFE00;
              out_nan_q     <= 1'b1;
              out_pinf_q    <= 1'b0;
              out_ninf_q    <= 1'b0;
              out_timeout_q <= 1'b1;
              out_valid_q   <= 1'b1;
              cnt           <= '0;
              state         <= ST_GAP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_HOLD: begin
          cnt   <= '0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
